jtcop_mcuport: RTL
==================

JTCOP_MCUPORT -- requirements
Module: jtcop_mcuport

Interface
REQ-001 SHALL have parameter OVR_STICKY, default 1; 1 keeps the overrun flag set until the MCU clears it, 0 clears it on the next main command write.
REQ-002 clk  in  1  system clock; all logic rising-edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 main_din  in  16  command word written by the 68000.
REQ-005 main_wr  in  1  one-clk command-write strobe from the 68000.
REQ-006 main_rd  in  1  68000 read/clear strobe, level for the duration of the access.
REQ-007 main_dout  out  16  response word returned to the 68000.
REQ-008 sec2  out  1  level interrupt request to the 68000, active-high.
REQ-009 mcu_p0_out  in  8  MCU port 0 output (data).
REQ-010 mcu_p0_in  out  8  MCU port 0 input (data).
REQ-011 mcu_p1_in  out  8  MCU port 1 input (status): bit0 cmd_full, bit1 rsp_pending, bit2 overrun, bits 7:3 = 1.
REQ-012 mcu_p2_out  in  8  MCU port 2 strobes, active-low: bit0 RDLO, bit1 RDHI, bit2 WRLO, bit3 WRHI, bit4 IRQM, bit5 ACK, bit6 OVCLR, bit7 unused.
REQ-013 mcu_int_n  out  1  MCU INT1 request, active-low.

Function
REQ-014 SHALL register mcu_p2_out each clk and act only on a falling edge (previous 1, current 0) of each strobe bit.
REQ-015 main_wr SHALL load cmd <= main_din, set cmd_full and drive mcu_int_n low on the next clk.
REQ-016 main_wr while cmd_full SHALL overwrite cmd and set overrun.
REQ-017 With OVR_STICKY=0, main_wr while cmd_full is clear SHALL clear overrun.
REQ-018 An ACK fall SHALL clear cmd_full and raise mcu_int_n.
REQ-019 If main_wr and an ACK fall occur in the same clk, the write SHALL win: cmd_full=1 and mcu_int_n=0.
REQ-020 A RDLO fall SHALL drive mcu_p0_in <= cmd[7:0] on the next clk and hold it until another read strobe.
REQ-021 A RDHI fall SHALL drive mcu_p0_in <= cmd[15:8] on the next clk and hold it until another read strobe.
REQ-022 Response FSM SHALL have states IDLE, LO (low byte written), RDY (sec2 high), WAIT (main reading).
REQ-023 A WRLO fall SHALL latch rsp[7:0] <= mcu_p0_out; IDLE->LO.
REQ-024 A WRHI fall SHALL latch rsp[15:8]; the state SHALL be unchanged.
REQ-025 An IRQM fall from IDLE or LO SHALL copy rsp to main_dout, set sec2 and go to RDY.
REQ-026 An IRQM fall in RDY SHALL update main_dout, keep sec2 high and stay in RDY.
REQ-027 A main_rd rise in RDY SHALL go to WAIT.
REQ-028 main_rd low in WAIT SHALL clear sec2 and go to IDLE.
REQ-029 An IRQM fall in WAIT SHALL update main_dout and go to RDY once main_rd drops, with sec2 remaining high.
REQ-030 main_dout SHALL change only on IRQM falls and SHALL be stable while main_rd is high.
REQ-031 rsp_pending SHALL be 1 in RDY and WAIT.
REQ-032 An OVCLR fall SHALL clear overrun.
REQ-033 An overrun set and an OVCLR fall in the same clk SHALL leave overrun set.
REQ-034 Several strobe falls in one clk SHALL each take effect; among read strobes RDHI SHALL beat RDLO.
REQ-035 Latency SHALL be one clk from strobe/edge to the visible output.

Reset
REQ-036 rst SHALL force cmd=0, rsp=0, main_dout=16'hffff, sec2=0, mcu_int_n=1, mcu_p0_in=8'hff, cmd_full=0, overrun=0, FSM=IDLE and the p2 history=8'hff.
REQ-037 rst asserted mid-transfer SHALL abort the transfer without any spurious edge: the p2 history of 8'hff means a low strobe held through reset release is seen as one fall.

Structure
REQ-038 A shared package SHALL hold the P2 bit-index constants, the P1 status bit indices and the response-FSM state encoding.
REQ-039 One sub-module, jtcop_mcuport_fall, SHALL implement the 8-bit registered falling-edge detector.
REQ-040 All other logic SHALL be flat within jtcop_mcuport.

Verification
REQ-041 Command path: main_wr with 16'h1234 -> cmd_full=1 and mcu_int_n=0; RDLO fall -> p0_in=8'h34; RDHI fall -> 8'h12; ACK fall -> mcu_int_n=1 and p1_in=8'hf8.
REQ-042 Response path: WRLO with 8'hcd, WRHI with 8'hab, IRQM -> sec2=1 and main_dout=16'habcd; main_rd pulse -> sec2=0 after main_rd falls, FSM=IDLE.
REQ-043 Overrun: two main_wr (16'h0001, then 16'h0002) before ACK -> cmd=16'h0002 and p1_in bit2=1; OVCLR fall -> bit2=0.
REQ-044 Collision: main_wr and an ACK fall in the same clk -> cmd_full=1 and mcu_int_n=0.
REQ-045 Re-raise: IRQM fall during WAIT with rsp 16'h5555 -> after main_rd drops, sec2 stays 1 and main_dout=16'h5555.
REQ-046 Reset: rst pulse while in RDY with p2 bit4 held low -> sec2=0 and main_dout=16'hffff; on release, exactly one IRQM edge re-enters RDY.

Source files
------------

// File: rtl/jtcop_mcuport_pkg.sv
// Shared constants for the 68000 <-> MCU mailbox port: P2 strobe bits, P1 status bits and
// the response-path state encoding.
package jtcop_mcuport_pkg;

    // Port 2 strobe bit indices (active-low on the MCU side)
    localparam int unsigned P2RdLo  = 0;
    localparam int unsigned P2RdHi  = 1;
    localparam int unsigned P2WrLo  = 2;
    localparam int unsigned P2WrHi  = 3;
    localparam int unsigned P2Irqm  = 4;
    localparam int unsigned P2Ack   = 5;
    localparam int unsigned P2OvClr = 6;

    // Port 1 status bit indices
    localparam int unsigned P1CmdFull = 0;
    localparam int unsigned P1RspPend = 1;
    localparam int unsigned P1Ovr     = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLo   = 2'd1,
        StRdy  = 2'd2,
        StWait = 2'd3
    } rsp_st_t;

endpackage

// File: rtl/jtcop_mcuport_fall.sv
// Registered 8-bit falling-edge detector. History resets to all ones so a strobe held low
// across reset release is reported as exactly one fall.
module jtcop_mcuport_fall (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_din,
    output logic [7:0] o_fall
);

    logic [7:0] r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_prev <= 8'hff;
        else     r_prev <= i_din;
    end

    assign o_fall = r_prev & ~i_din;

endmodule

// File: rtl/jtcop_mcuport.sv
// Mailbox between the 68000 and the protection MCU: a 16-bit command register read
// bytewise by the MCU and a 16-bit response register raised to the 68000 through sec2.
module jtcop_mcuport
    import jtcop_mcuport_pkg::*;
#(
    parameter int unsigned OVR_STICKY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] main_din,
    input  logic        main_wr,
    input  logic        main_rd,
    output logic [15:0] main_dout,
    output logic        sec2,
    input  logic [7:0]  mcu_p0_out,
    output logic [7:0]  mcu_p0_in,
    output logic [7:0]  mcu_p1_in,
    input  logic [7:0]  mcu_p2_out,
    output logic        mcu_int_n
);

    logic [7:0]  w_fall;
    logic [15:0] r_cmd, w_cmd_d;
    logic        r_cmd_full, w_cmd_full_d;
    logic        r_ovr, w_ovr_d;
    logic [7:0]  r_p0, w_p0_d;
    logic [15:0] r_rsp, w_rsp_d;
    logic [15:0] r_dout, w_dout_d;
    logic        r_sec2, w_sec2_d;
    logic        r_rd, w_rd_rise;
    logic        r_pend, w_pend_d;
    logic [15:0] r_hold, w_hold_d;
    rsp_st_t     r_st, w_st_d;

    jtcop_mcuport_fall u_fall (
        .clk    (clk),
        .rst    (rst),
        .i_din  (mcu_p2_out),
        .o_fall (w_fall)
    );

    assign w_rd_rise = main_rd & ~r_rd;

    always_comb begin
        w_cmd_d      = r_cmd;
        w_cmd_full_d = r_cmd_full;
        w_ovr_d      = r_ovr;
        w_p0_d       = r_p0;
        w_rsp_d      = r_rsp;
        w_dout_d     = r_dout;
        w_sec2_d     = r_sec2;
        w_pend_d     = r_pend;
        w_hold_d     = r_hold;
        w_st_d       = r_st;

        // Command side: a write beats both ACK and OVCLR in the same cycle
        if (w_fall[P2OvClr]) w_ovr_d = 1'b0;
        if (main_wr) begin
            w_cmd_d      = main_din;
            w_cmd_full_d = 1'b1;
            if (r_cmd_full)           w_ovr_d = 1'b1;
            else if (OVR_STICKY == 0) w_ovr_d = 1'b0;
        end else if (w_fall[P2Ack]) begin
            w_cmd_full_d = 1'b0;
        end

        if (w_fall[P2RdHi])      w_p0_d = r_cmd[15:8];
        else if (w_fall[P2RdLo]) w_p0_d = r_cmd[7:0];

        if (w_fall[P2WrLo]) w_rsp_d[7:0]  = mcu_p0_out;
        if (w_fall[P2WrHi]) w_rsp_d[15:8] = mcu_p0_out;

        unique case (r_st)
            StIdle, StLo: begin
                if (w_fall[P2Irqm]) begin
                    w_dout_d = w_rsp_d;
                    w_sec2_d = 1'b1;
                    w_st_d   = StRdy;
                end else if (w_fall[P2WrLo]) begin
                    w_st_d = StLo;
                end
            end
            StRdy: begin
                if (w_rd_rise) begin
                    w_st_d = StWait;
                    if (w_fall[P2Irqm]) begin
                        w_pend_d = 1'b1;
                        w_hold_d = w_rsp_d;
                    end
                end else if (w_fall[P2Irqm]) begin
                    w_dout_d = w_rsp_d;
                end
            end
            StWait: begin
                // A new response during the read is parked so main_dout stays stable
                if (w_fall[P2Irqm]) begin
                    w_pend_d = 1'b1;
                    w_hold_d = w_rsp_d;
                end
                if (!main_rd) begin
                    w_pend_d = 1'b0;
                    if (w_fall[P2Irqm]) begin
                        w_dout_d = w_rsp_d;
                        w_st_d   = StRdy;
                    end else if (r_pend) begin
                        w_dout_d = r_hold;
                        w_st_d   = StRdy;
                    end else begin
                        w_sec2_d = 1'b0;
                        w_st_d   = StIdle;
                    end
                end
            end
            default: w_st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd      <= 16'h0000;
            r_cmd_full <= 1'b0;
            r_ovr      <= 1'b0;
            r_p0       <= 8'hff;
            r_rsp      <= 16'h0000;
            r_dout     <= 16'hffff;
            r_sec2     <= 1'b0;
            r_rd       <= 1'b0;
            r_pend     <= 1'b0;
            r_hold     <= 16'h0000;
            r_st       <= StIdle;
        end else begin
            r_cmd      <= w_cmd_d;
            r_cmd_full <= w_cmd_full_d;
            r_ovr      <= w_ovr_d;
            r_p0       <= w_p0_d;
            r_rsp      <= w_rsp_d;
            r_dout     <= w_dout_d;
            r_sec2     <= w_sec2_d;
            r_rd       <= main_rd;
            r_pend     <= w_pend_d;
            r_hold     <= w_hold_d;
            r_st       <= w_st_d;
        end
    end

    always_comb begin
        mcu_p1_in            = 8'hff;
        mcu_p1_in[P1CmdFull] = r_cmd_full;
        mcu_p1_in[P1RspPend] = (r_st == StRdy) || (r_st == StWait);
        mcu_p1_in[P1Ovr]     = r_ovr;
    end

    assign mcu_int_n = ~r_cmd_full;
    assign mcu_p0_in = r_p0;
    assign main_dout = r_dout;
    assign sec2      = r_sec2;

endmodule
